alu_muldiv_unit: RTL and testbench

- Parametrised next-generation execute-stage ALU for the pipelined MIPS core.
- Adds iterative multiply/divide with HI/LO registers, a start/busy/done handshake and a pipeline flush.
- Keeps the existing single-cycle AND/OR/ADD/SUB/SLT operations, registered with 1-cycle latency.
- The hazard unit stalls the pipeline on busy.

---
 rtl/alu_muldiv_unit.sv | 216 +++++++++++++++++++++
 tb/tb_alu_muldiv_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_unit.sv
// Execute-stage ALU: single-cycle logic/arith plus iterative
// signed/unsigned multiply and divide writing HI/LO.
module alu_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataOut,
  output logic             isZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   araw_q, araw_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               isdiv_q, isdiv_d;
  logic               divz_q, divz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;

  logic               is_mul, is_div, sgn_op;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic               slt, sltu;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign is_mul = (op[3:1] == 3'b100);
  assign is_div = (op[3:1] == 3'b101);
  assign sgn_op = ~op[0];
  assign a_neg  = sgn_op & dataA[WIDTH-1];
  assign b_neg  = sgn_op & dataB[WIDTH-1];
  assign a_abs  = a_neg ? -dataA : dataA;
  assign b_abs  = b_neg ? -dataB : dataB;
  assign slt    = $signed(dataA) < $signed(dataB);
  assign sltu   = dataA < dataB;

  always_comb begin
    alu_res = {WIDTH{1'b0}};
    case (op)
      4'b0000: alu_res = dataA & dataB;
      4'b0001: alu_res = dataA | dataB;
      4'b0010: alu_res = dataA + dataB;
      4'b0110: alu_res = dataA - dataB;
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, slt};
      4'b0011: alu_res = {{(WIDTH-1){1'b0}}, sltu};
      4'b1100: alu_res = hi_q;
      4'b1101: alu_res = lo_q;
      default: alu_res = {WIDTH{1'b0}};
    endcase
  end

  // shift-add: upper half accumulates, multiplier shifts out of lower half
  assign msum = {1'b0, work_q[2*WIDTH-1:WIDTH]}
              + {1'b0, (work_q[0] ? opnd_q : {WIDTH{1'b0}})};
  assign mul_next = {msum, work_q[WIDTH-1:1]};

  // restoring: upper half is remainder, lower half dividend/quotient
  assign trial = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]}
               - {1'b0, opnd_q};
  assign div_next = trial[WIDTH]
                  ? {work_q[2*WIDTH-2:0], 1'b0}
                  : {trial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_q ? -work_q : work_q;
  assign q_fix    = neg_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
  assign r_fix    = rneg_q ? -work_q[2*WIDTH-1:WIDTH]
                           : work_q[2*WIDTH-1:WIDTH];

  always_comb begin
    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (isdiv_q) begin
      if (divz_q) begin
        fix_hi = araw_q;
        fix_lo = {WIDTH{1'b1}};
      end else begin
        fix_hi = r_fix;
        fix_lo = q_fix;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    opnd_d  = opnd_q;
    araw_d  = araw_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    isdiv_d = isdiv_q;
    divz_d  = divz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dout_d  = dout_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (is_mul | is_div) begin
              state_d = is_mul ? S_MUL : S_DIV;
              cnt_d   = CNT_INIT;
              work_d  = {{WIDTH{1'b0}}, a_abs};
              opnd_d  = b_abs;
              araw_d  = dataA;
              neg_d   = a_neg ^ b_neg;
              rneg_d  = a_neg;
              isdiv_d = is_div;
              divz_d  = (dataB == {WIDTH{1'b0}});
            end else begin
              dout_d = alu_res;
              zero_d = (alu_res == {WIDTH{1'b0}});
              done_d = 1'b1;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_d = S_FIX;
          end else begin
            work_d = (state_q == S_MUL) ? mul_next : div_next;
            cnt_d  = cnt_q - CNT_ONE;
          end
        end
        S_FIX: begin
          hi_d    = fix_hi;
          lo_d    = fix_lo;
          dout_d  = fix_lo;
          zero_d  = (fix_lo == {WIDTH{1'b0}});
          done_d  = 1'b1;
          state_d = S_DONE;
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      work_q  <= {(2*WIDTH){1'b0}};
      opnd_q  <= {WIDTH{1'b0}};
      araw_q  <= {WIDTH{1'b0}};
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      isdiv_q <= 1'b0;
      divz_q  <= 1'b0;
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      dout_q  <= {WIDTH{1'b0}};
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      opnd_q  <= opnd_d;
      araw_q  <= araw_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      isdiv_q <= isdiv_d;
      divz_q  <= divz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dout_q  <= dout_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign dataOut = dout_q;
  assign isZero  = zero_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed bench for alu_muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_alu_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, flush;
  logic [3:0]  op;
  logic [31:0] dataA, dataB;
  logic        busy, done, isZero;
  logic [31:0] dataOut, hi, lo;

  logic        start8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8;
  logic        flush8;
  logic        busy8, done8, zero8;
  logic [7:0]  dout8, hi8, lo8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .dataA(dataA), .dataB(dataB), .flush(flush),
    .busy(busy), .done(done), .dataOut(dataOut),
    .isZero(isZero), .hi(hi), .lo(lo)
  );

  alu_muldiv_unit #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8),
    .dataA(a8), .dataB(b8), .flush(flush8),
    .busy(busy8), .done(done8), .dataOut(dout8),
    .isZero(zero8), .hi(hi8), .lo(lo8)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [3:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input int exp_lat);
    int   lat;
    logic b1;
    op = o; dataA = a; dataB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    b1  = 1'b0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) b1 = busy;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy_done"}, busy, exp_lat > 0);
    if (exp_lat > 0) chk({tag, "_busy_e1"}, b1, 1'b1);
    @(posedge clk); #1;
    chk({tag, "_tail_done"}, done, 1'b0);
    chk({tag, "_tail_busy"}, busy, 1'b0);
  endtask

  logic [3:0]  t_op [9] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111,
                            4'b0011, 4'b0011, 4'b0110, 4'b0100};
  logic [31:0] t_a  [9] = '{32'h7FFFFFFF, 32'd5, 32'hF0F0FF00,
                            32'hF0F0FF00, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'd1, 32'd3, 32'h12345678};
  logic [31:0] t_b  [9] = '{32'd1, 32'd5, 32'h0FF0F0F0, 32'h0FF0F0F0,
                            32'd1, 32'd1, 32'hFFFFFFFF, 32'd5,
                            32'h9ABCDEF0};
  logic [31:0] t_y  [9] = '{32'h80000000, 32'd0, 32'h00F0F000,
                            32'hFFF0FFF0, 32'd1, 32'd0, 32'd1,
                            32'hFFFFFFFE, 32'd0};

  initial begin
    int e;
    int ndone;
    reset = 1'b0; start = 1'b0; flush = 1'b0;
    op = 4'd0; dataA = '0; dataB = '0;
    start8 = 1'b0; flush8 = 1'b0; op8 = 4'd0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dout", dataOut, 32'd0);
    chk("rst_zero", isZero, 1'b0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      do_op($sformatf("alu%0d", i), t_op[i], t_a[i], t_b[i], 0);
      chk($sformatf("alu%0d_y", i), dataOut, t_y[i]);
      chk($sformatf("alu%0d_z", i), isZero, t_y[i] == 32'd0);
    end

    do_op("mult", 4'b1000, 32'hFFFFFFFD, 32'd5, 34);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFF1);
    chk("mult_dout", dataOut, 32'hFFFFFFF1);
    do_op("multu", 4'b1001, 32'hFFFFFFFD, 32'd5, 34);
    chk("multu_hi", hi, 32'h00000004);
    chk("multu_lo", lo, 32'hFFFFFFF1);
    do_op("div", 4'b1010, 32'hFFFFFFF9, 32'd2, 34);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    do_op("divu0", 4'b1011, 32'd7, 32'd0, 34);
    chk("divu0_lo", lo, 32'hFFFFFFFF);
    chk("divu0_hi", hi, 32'd7);
    do_op("divov", 4'b1010, 32'h80000000, 32'hFFFFFFFF, 34);
    chk("divov_lo", lo, 32'h80000000);
    chk("divov_hi", hi, 32'd0);
    chk("divov_z", isZero, 1'b0);

    op = 4'b1010; dataA = 32'd100; dataB = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = 0;
    while (!done && e < 200) begin
      @(posedge clk); #1;
      e++;
      op = 4'b0010; dataA = 32'd1; dataB = 32'd1;
      start = (e >= 5 && e <= 8);
    end
    start = 1'b0;
    chk("ign_lat", 64'(e), 64'd34);
    chk("ign_lo", lo, 32'd14);
    chk("ign_hi", hi, 32'd2);
    @(posedge clk); #1;
    chk("ign_tail_done", done, 1'b0);
    do_op("mflo", 4'b1101, 32'd0, 32'd0, 0);
    chk("mflo_y", dataOut, 32'd14);
    do_op("mfhi", 4'b1100, 32'd0, 32'd0, 0);
    chk("mfhi_y", dataOut, 32'd2);

    do_op("pre", 4'b1001, 32'h80000001, 32'd2, 34);
    chk("pre_hi", hi, 32'd1);
    chk("pre_lo", lo, 32'd2);
    op = 4'b1000; dataA = 32'd3; dataB = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("fl_busy_pre", busy, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl_busy", busy, 1'b0);
    chk("fl_done", done, 1'b0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("fl_ndone", 64'(ndone), 64'd0);
    chk("fl_hi", hi, 32'd1);
    chk("fl_lo", lo, 32'd2);
    chk("fl_dout", dataOut, 32'd2);
    op = 4'b0010; dataA = 32'd5; dataB = 32'd6;
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flst_done", done, 1'b0);
    chk("flst_dout", dataOut, 32'd2);

    op = 4'b1010; dataA = 32'd100; dataB = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_dout", dataOut, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    do_op("multu34", 4'b1001, 32'd3, 32'd4, 34);
    chk("multu34_lo", lo, 32'd12);
    chk("multu34_hi", hi, 32'd0);

    op8 = 4'b1000; a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    e = 0;
    while (!done8 && e < 200) begin
      @(posedge clk); #1;
      e++;
    end
    chk("w8_lat", 64'(e), 64'd10);
    chk("w8_hi", hi8, 8'h40);
    chk("w8_lo", lo8, 8'h00);
    chk("w8_dout", dout8, 8'h00);
    chk("w8_zero", zero8, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
